// File: rtl/optic_tx_pkg.sv
// optic_tx_pkg
//   Shared constants and helpers for the optic TX frame loader slice.
//   - ST_* : loader state encoding (IDLE -> FLUSH -> EXTEND -> GAP -> IDLE)
//   - BUF_DEPTH : shadow buffer depth for the default 14-channel build
//   - clog2 : ceiling log2 used to size channel / index / counter fields
package optic_tx_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_EXTEND = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  localparam int CH_NUM_DEF = 14;
  localparam int BUF_DEPTH  = 2 * CH_NUM_DEF;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/optic_pulse_extend.sv
// optic_pulse_extend
//   Counter-based level stretcher. A start pulse drives level high for
//   EXT_LEN cycles, then holds it low for GAP_LEN cycles before re-arming.
//   Ports:
//     clk_sys, reset : clock and synchronous active-high reset
//     start          : one-cycle trigger, honoured only while idle
//     level          : registered stretched level
//     ext_done       : high in the last high cycle (high phase ends next edge)
//     done           : high in the last gap cycle (extender idles next edge)
module optic_pulse_extend
  import optic_tx_pkg::*;
#(
  parameter int EXT_LEN = 8,
  parameter int GAP_LEN = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic start,
  output logic level,
  output logic ext_done,
  output logic done
);

  localparam int MAX_LEN = (EXT_LEN > GAP_LEN) ? EXT_LEN : GAP_LEN;
  localparam int CNT_W   = clog2(MAX_LEN + 1);

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_EXT  = 2'd1;
  localparam logic [1:0] PH_GAP  = 2'd2;

  logic [1:0]       ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // Phase sequencing and counter for the high and gap windows.
  always_comb begin
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    ext_done = (ph_q == PH_EXT) && (cnt_q == CNT_W'(EXT_LEN - 1));
    done     = (ph_q == PH_GAP) && (cnt_q == CNT_W'(GAP_LEN - 1));
    case (ph_q)
      PH_IDLE: begin
        if (start) begin
          ph_d    = PH_EXT;
          cnt_d   = {CNT_W{1'b0}};
          level_d = 1'b1;
        end else begin
          level_d = 1'b0;
        end
      end
      PH_EXT: begin
        if (ext_done) begin
          ph_d    = PH_GAP;
          cnt_d   = {CNT_W{1'b0}};
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PH_GAP: begin
        if (done) begin
          ph_d  = PH_IDLE;
          cnt_d = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        ph_d    = PH_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        level_d = 1'b0;
      end
    endcase
  end

  // Phase, counter and level registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ph_q    <= PH_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      level_q <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/optic_tx_frame_loader.sv
// optic_tx_frame_loader
//   Buffers per-channel TX command words (CH_NUM channels x 2 words) and, on
//   frame_end, replays them as one-hot channel writes to the optic encoder,
//   then raises sfp_rx_end_extend for EXT_LEN cycles followed by a GAP_LEN
//   quiet window so the slower TX clock domain can see the start level.
//   Ports:
//     clk_sys, reset              : clock, synchronous active-high reset
//     cmd_valid/cmd_ready         : command handshake (ready only in IDLE)
//     cmd_ch, cmd_word, cmd_data  : target channel, word select, payload
//     frame_end                   : end-of-frame strobe, starts the flush
//     tx_wea_s, tx_waddr, tx_wdata: registered encoder write port
//     sfp_rx_end_extend           : stretched transmit-start level
//     busy                        : loader not in IDLE
//     cmd_err                     : pulse after an out-of-range channel command
//     frame_ovr                   : sticky, frame_end seen while busy
module optic_tx_frame_loader
  import optic_tx_pkg::*;
#(
  parameter int CH_NUM  = 14,
  parameter int CH_W    = 4,
  parameter int EXT_LEN = 8,
  parameter int GAP_LEN = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic              cmd_word,
  input  logic [31:0]       cmd_data,
  input  logic              frame_end,
  output logic [CH_NUM-1:0] tx_wea_s,
  output logic              tx_waddr,
  output logic [31:0]       tx_wdata,
  output logic              sfp_rx_end_extend,
  output logic              busy,
  output logic              cmd_err,
  output logic              frame_ovr
);

  localparam int BUF_D = 2 * CH_NUM;
  localparam int IDX_W = clog2(BUF_D);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [BUF_D-1:0]  valid_q, valid_d;
  logic [CH_NUM-1:0] wea_q, wea_d;
  logic              waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cmd_err_q, cmd_err_d;
  logic              ovr_q, ovr_d;
  logic              start_q, start_d;
  logic [31:0]       mem_q [BUF_D];

  logic              accept_s;
  logic              ch_bad_s;
  logic              wr_en_s;
  logic [CH_W:0]     wr_idx_s;
  logic              last_k_s;
  logic              ext_done_s;
  logic              gap_done_s;

  // Command acceptance, buffer bookkeeping, flush sequencing and write port.
  always_comb begin
    accept_s  = cmd_valid & (state_q == ST_IDLE);
    ch_bad_s  = ({1'b0, cmd_ch} >= (CH_W + 1)'(CH_NUM));
    wr_en_s   = accept_s & ~ch_bad_s;
    wr_idx_s  = {cmd_ch, cmd_word};
    last_k_s  = (k_q == IDX_W'(BUF_D - 1));

    state_d   = state_q;
    k_d       = k_q;
    valid_d   = valid_q;
    wea_d     = {CH_NUM{1'b0}};
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    start_d   = 1'b0;
    cmd_err_d = accept_s & ch_bad_s;
    ovr_d     = ovr_q | (frame_end & (state_q != ST_IDLE));

    if (wr_en_s) begin
      valid_d[wr_idx_s] = 1'b1;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        // A command accepted alongside frame_end is already in valid_d and
        // mem, so it is picked up by this flush.
        if (frame_end) begin
          state_d = ST_FLUSH;
          k_d     = {IDX_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // Every slot costs one cycle whether or not it holds data.
        if (valid_q[k_q]) begin
          wea_d   = CH_NUM'(1) << k_q[IDX_W-1:1];
          waddr_d = k_q[0];
          wdata_d = mem_q[k_q];
        end else begin
          wea_d = {CH_NUM{1'b0}};
        end
        if (last_k_s) begin
          valid_d = {BUF_D{1'b0}};
          state_d = ST_EXTEND;
          start_d = 1'b1;
          k_d     = {IDX_W{1'b0}};
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      ST_EXTEND: begin
        if (ext_done_s) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_EXTEND;
        end
      end
      ST_GAP: begin
        if (gap_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      k_q       <= {IDX_W{1'b0}};
      valid_q   <= {BUF_D{1'b0}};
      wea_q     <= {CH_NUM{1'b0}};
      waddr_q   <= 1'b0;
      wdata_q   <= 32'd0;
      cmd_err_q <= 1'b0;
      ovr_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      valid_q   <= valid_d;
      wea_q     <= wea_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      cmd_err_q <= cmd_err_d;
      ovr_q     <= ovr_d;
      start_q   <= start_d;
    end
  end

  // Shadow buffer payload; the valid bits alone say what is meaningful.
  always_ff @(posedge clk_sys) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= cmd_data;
    end
  end

  // start_q is one cycle late so the stretched level rises one cycle after
  // the last flush slot.
  optic_pulse_extend #(
    .EXT_LEN (EXT_LEN),
    .GAP_LEN (GAP_LEN)
  ) u_extend (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (start_q),
    .level    (sfp_rx_end_extend),
    .ext_done (ext_done_s),
    .done     (gap_done_s)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign tx_wea_s  = wea_q;
  assign tx_waddr  = waddr_q;
  assign tx_wdata  = wdata_q;
  assign cmd_err   = cmd_err_q;
  assign frame_ovr = ovr_q;

endmodule

// File: tb/tb_optic_tx_frame_loader.sv
// tb_optic_tx_frame_loader
//   Directed plus randomized bench for optic_tx_frame_loader (14 channels,
//   EXT_LEN 8, GAP_LEN 4). A shadow-array model predicts every write strobe,
//   the stretched level window, busy, cmd_err and frame_ovr per cycle.
module tb_optic_tx_frame_loader;

  localparam int CH_NUM  = 14;
  localparam int CH_W    = 4;
  localparam int EXT_LEN = 8;
  localparam int GAP_LEN = 4;
  localparam int NENT    = 2 * CH_NUM;
  localparam int FLEN    = NENT + EXT_LEN + GAP_LEN + 1;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch;
  logic              cmd_word;
  logic [31:0]       cmd_data;
  logic              frame_end;
  logic [CH_NUM-1:0] tx_wea_s;
  logic              tx_waddr;
  logic [31:0]       tx_wdata;
  logic              sfp_rx_end_extend;
  logic              busy;
  logic              cmd_err;
  logic              frame_ovr;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: buffered entries, last write port values, sticky flag.
  logic [31:0] m_data [NENT];
  bit          m_vld  [NENT];
  logic        m_addr;
  logic [31:0] m_wdata;
  bit          m_ovr;

  int          nw;
  logic [3:0]  rch;
  logic        rw;
  logic [31:0] rd;

  optic_tx_frame_loader #(
    .CH_NUM  (CH_NUM),
    .CH_W    (CH_W),
    .EXT_LEN (EXT_LEN),
    .GAP_LEN (GAP_LEN)
  ) dut (
    .clk_sys           (clk_sys),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_ch            (cmd_ch),
    .cmd_word          (cmd_word),
    .cmd_data          (cmd_data),
    .frame_end         (frame_end),
    .tx_wea_s          (tx_wea_s),
    .tx_waddr          (tx_waddr),
    .tx_wdata          (tx_wdata),
    .sfp_rx_end_extend (sfp_rx_end_extend),
    .busy              (busy),
    .cmd_err           (cmd_err),
    .frame_ovr         (frame_ovr)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_data[i] = 32'd0;
      m_vld[i]  = 1'b0;
    end
    m_addr  = 1'b0;
    m_wdata = 32'd0;
    m_ovr   = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    chk({name, ":wea"},   32'(tx_wea_s), 32'd0);
    chk({name, ":waddr"}, 32'(tx_waddr), 32'd0);
    chk({name, ":wdata"}, tx_wdata, 32'd0);
    chk({name, ":ext"},   32'(sfp_rx_end_extend), 32'd0);
    chk({name, ":busy"},  32'(busy), 32'd0);
    chk({name, ":ready"}, 32'(cmd_ready), 32'd1);
    chk({name, ":err"},   32'(cmd_err), 32'd0);
    chk({name, ":ovr"},   32'(frame_ovr), 32'd0);
  endtask

  task automatic write_cmd(input logic [3:0] ch, input logic w, input logic [31:0] d);
    int idx;
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_word  = w;
    cmd_data  = d;
    @(posedge clk_sys);
    #1;
    cmd_valid = 1'b0;
    if (int'(ch) < CH_NUM) begin
      idx         = int'(ch) * 2 + int'(w);
      m_data[idx] = d;
      m_vld[idx]  = 1'b1;
    end
    chk("wr:cmd_err", 32'(cmd_err), (int'(ch) >= CH_NUM) ? 32'd1 : 32'd0);
    chk("wr:ready", 32'(cmd_ready), 32'd1);
  endtask

  // Issue frame_end (optionally with a coincident command) and check every
  // cycle of the flush/extend/gap sequence. ovr_at: cycle offset of a second
  // frame_end (0 = none). abort_at: offset at which reset is sampled (0 = none).
  task automatic run_frame(input string name, input bit with_cmd, input logic [3:0] c_ch,
                           input logic c_w, input logic [31:0] c_d,
                           input int ovr_at, input int abort_at);
    logic [31:0]       s_data [NENT];
    bit                s_vld  [NENT];
    logic [CH_NUM-1:0] exp_wea;
    bit                bad;
    int                k;
    bad = with_cmd && (int'(c_ch) >= CH_NUM);
    if (with_cmd && !bad) begin
      m_data[int'(c_ch) * 2 + int'(c_w)] = c_d;
      m_vld[int'(c_ch) * 2 + int'(c_w)]  = 1'b1;
    end
    s_data    = m_data;
    s_vld     = m_vld;
    frame_end = 1'b1;
    cmd_valid = with_cmd;
    cmd_ch    = c_ch;
    cmd_word  = c_w;
    cmd_data  = c_d;
    @(posedge clk_sys);
    #1;
    frame_end = 1'b0;
    cmd_valid = 1'b0;
    chk({name, ":busy0"}, 32'(busy), 32'd1);
    chk({name, ":ready0"}, 32'(cmd_ready), 32'd0);
    chk({name, ":err0"}, 32'(cmd_err), bad ? 32'd1 : 32'd0);
    for (int n = 1; n <= FLEN; n++) begin
      frame_end = (n == ovr_at);
      if (n == abort_at) begin
        reset = 1'b1;
      end
      @(posedge clk_sys);
      #1;
      frame_end = 1'b0;
      if (n == abort_at) begin
        reset = 1'b0;
        model_reset();
        check_reset_state({name, ":abort"});
        return;
      end
      if (n == ovr_at) begin
        m_ovr = 1'b1;
      end
      exp_wea = '0;
      if (n <= NENT) begin
        k = n - 1;
        if (s_vld[k]) begin
          exp_wea[k / 2] = 1'b1;
          m_addr         = ((k % 2) == 1);
          m_wdata        = s_data[k];
        end
      end
      if (n == NENT) begin
        for (int i = 0; i < NENT; i++) begin
          m_vld[i] = 1'b0;
        end
      end
      chk({name, ":wea"},   32'(tx_wea_s), 32'(exp_wea));
      chk({name, ":waddr"}, 32'(tx_waddr), 32'(m_addr));
      chk({name, ":wdata"}, tx_wdata, m_wdata);
      chk({name, ":ext"},   32'(sfp_rx_end_extend),
          (n > NENT && n <= NENT + EXT_LEN) ? 32'd1 : 32'd0);
      chk({name, ":busy"},  32'(busy), (n < FLEN) ? 32'd1 : 32'd0);
      chk({name, ":ready"}, 32'(cmd_ready), (n == FLEN) ? 32'd1 : 32'd0);
      chk({name, ":err"},   32'(cmd_err), 32'd0);
      chk({name, ":ovr"},   32'(frame_ovr), 32'(m_ovr));
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_ch    = 4'd0;
    cmd_word  = 1'b0;
    cmd_data  = 32'd0;
    frame_end = 1'b0;
    model_reset();
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    check_reset_state("reset");
    reset = 1'b0;

    // Single write: ch3/word1 lands at slot 7.
    write_cmd(4'd3, 1'b1, 32'hA5A5_0003);
    run_frame("single", 1'b0, 4'd0, 1'b0, 32'd0, 0, 0);

    // Full load with data = {ch, word}, then an empty re-flush.
    for (int c = 0; c < CH_NUM; c++) begin
      for (int w = 0; w < 2; w++) begin
        write_cmd(4'(c), 1'(w), 32'(c * 2 + w));
      end
    end
    run_frame("full", 1'b0, 4'd0, 1'b0, 32'd0, 0, 0);
    run_frame("empty", 1'b0, 4'd0, 1'b0, 32'd0, 0, 0);

    // Overwrite, last write coincident with frame_end.
    write_cmd(4'd0, 1'b0, 32'h0000_0001);
    run_frame("coinc", 1'b1, 4'd0, 1'b0, 32'h0000_0002, 0, 0);

    // Out-of-range channel, plus frame_end during flush.
    write_cmd(4'd15, 1'b0, 32'hDEAD_BEEF);
    write_cmd(4'd14, 1'b1, 32'hBAD0_0014);
    write_cmd(4'd13, 1'b1, 32'h1300_0001);
    run_frame("ovr", 1'b1, 4'd15, 1'b1, 32'hBAD0_0015, 10, 0);

    // Randomized frames; frame_ovr remains set throughout.
    for (int r = 0; r < 4; r++) begin
      nw = int'($urandom_range(0, 30));
      for (int i = 0; i < nw; i++) begin
        rch = 4'($urandom_range(0, 15));
        rw  = 1'($urandom_range(0, 1));
        rd  = $urandom;
        write_cmd(rch, rw, rd);
      end
      rch = 4'($urandom_range(0, 15));
      rw  = 1'($urandom_range(0, 1));
      rd  = $urandom;
      run_frame("rand", 1'($urandom_range(0, 1)), rch, rw, rd, 0, 0);
    end

    // Reset in the middle of the flush, then a flush with nothing buffered.
    for (int i = 0; i < 20; i++) begin
      write_cmd(4'($urandom_range(0, 13)), 1'($urandom_range(0, 1)), $urandom);
    end
    run_frame("abort", 1'b0, 4'd0, 1'b0, 32'd0, 0, 20);
    run_frame("post", 1'b0, 4'd0, 1'b0, 32'd0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
